// File: rtl/escalonador_alarmes.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_alarmes
// Description : Round-robin alarm sequencer. One shared threshold check with
//               per-zone persistence filtering, latching and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module escalonador_alarmes #(
    parameter int NZ          = 4,
    parameter int PERSIST     = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*NZ-1:0]    temp,
    input  logic [4*NZ-1:0]    pressao,
    input  logic [12*NZ-1:0]   radiacao,
    input  logic               reconhecer,
    input  logic [3:0]         reconhecer_zona,
    output logic [NZ-1:0]      alarme_zona,
    output logic               alarmeSonoro,
    output logic               scram,
    output logic [3:0]         zona_atual,
    output logic               varredura_fim
);

    localparam int                c_cnt_w      = $clog2(PERSIST + 1);
    localparam int                c_to_w       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_persist    = c_cnt_w'(PERSIST);
    localparam logic [c_cnt_w-1:0] c_persist_m1 = c_cnt_w'(PERSIST - 1);
    localparam logic [c_to_w-1:0]  c_timeout    = c_to_w'(ACK_TIMEOUT);
    localparam logic [3:0]         c_ultima     = 4'(NZ - 1);

    typedef enum logic [0:0] {
        CAPTURA = 1'b0,
        AVALIA  = 1'b1
    } estado_t;

    estado_t                      estado_q, estado_d;
    logic [3:0]                   zona_q, zona_d;
    logic [7:0]                   temp_q;
    logic [3:0]                   pres_q;
    logic [11:0]                  rad_q;
    logic [NZ-1:0][c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [NZ-1:0]                pend_q, pend_d;
    logic [NZ-1:0]                alarme_q, alarme_d;
    logic [c_to_w-1:0]            timeout_q, timeout_d;
    logic                         scram_q, scram_d;
    logic                         fim_q, fim_d;

    logic [7:0]                   w_temp_z [NZ];
    logic [3:0]                   w_pres_z [NZ];
    logic [11:0]                  w_rad_z  [NZ];
    logic [7:0]                   w_temp_sel;
    logic [3:0]                   w_pres_sel;
    logic [11:0]                  w_rad_sel;
    logic                         w_viol;
    logic [NZ-1:0]                w_latch;

    for (genvar z = 0; z < NZ; z++) begin : g_fatias
        assign w_temp_z[z] = temp[8*z +: 8];
        assign w_pres_z[z] = pressao[4*z +: 4];
        assign w_rad_z[z]  = radiacao[12*z +: 12];
    end

    always_comb begin
        w_temp_sel = '0;
        w_pres_sel = '0;
        w_rad_sel  = '0;
        for (int z = 0; z < NZ; z++) begin
            if (zona_q == 4'(z)) begin
                w_temp_sel = w_temp_z[z];
                w_pres_sel = w_pres_z[z];
                w_rad_sel  = w_rad_z[z];
            end
        end
    end

    assign w_viol = (temp_q >= 8'd40) | (pres_q >= 4'd7) | (rad_q >= 12'd1000);

    always_comb begin
        estado_d  = estado_q;
        zona_d    = zona_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        alarme_d  = alarme_q;
        timeout_d = timeout_q;
        scram_d   = scram_q;
        fim_d     = 1'b0;
        w_latch   = '0;

        case (estado_q)
            CAPTURA: begin
                estado_d = AVALIA;
                fim_d    = (zona_q == c_ultima);
            end
            default: begin
                estado_d = CAPTURA;
                zona_d   = (zona_q == c_ultima) ? 4'd0 : zona_q + 4'd1;
                for (int z = 0; z < NZ; z++) begin
                    if (zona_q == 4'(z)) begin
                        if (w_viol) begin
                            if (cnt_q[z] != c_persist) begin
                                cnt_d[z]   = cnt_q[z] + 1'b1;
                                w_latch[z] = (cnt_q[z] == c_persist_m1);
                            end
                        end else begin
                            cnt_d[z] = '0;
                            if (!pend_q[z]) begin
                                alarme_d[z] = 1'b0;
                            end
                        end
                    end
                end
            end
        endcase

        // Only indices below NZ can match, so out-of-range acks fall through.
        if (reconhecer) begin
            for (int z = 0; z < NZ; z++) begin
                if (reconhecer_zona == 4'(z)) begin
                    pend_d[z] = 1'b0;
                end
            end
        end
        pend_d   = pend_d | w_latch;
        alarme_d = alarme_d | w_latch;

        if (|pend_q) begin
            if (timeout_q != c_timeout) begin
                timeout_d = timeout_q + 1'b1;
            end
            if (timeout_d == c_timeout) begin
                scram_d = 1'b1;
            end
        end else begin
            timeout_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= CAPTURA;
            zona_q    <= '0;
            temp_q    <= '0;
            pres_q    <= '0;
            rad_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            alarme_q  <= '0;
            timeout_q <= '0;
            scram_q   <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            zona_q    <= zona_d;
            if (estado_q == CAPTURA) begin
                temp_q <= w_temp_sel;
                pres_q <= w_pres_sel;
                rad_q  <= w_rad_sel;
            end
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            alarme_q  <= alarme_d;
            timeout_q <= timeout_d;
            scram_q   <= scram_d;
            fim_q     <= fim_d;
        end
    end

    assign alarme_zona   = alarme_q;
    assign alarmeSonoro  = |pend_q;
    assign scram         = scram_q;
    assign zona_atual    = zona_q;
    assign varredura_fim = fim_q;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_alarmes.sv
`default_nettype none
// ============================================================================
// Module      : tb_escalonador_alarmes
// Description : Scenario bench for escalonador_alarmes with a timed scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escalonador_alarmes;

    localparam int NZ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8*NZ-1:0]   temp;
    logic [4*NZ-1:0]   pressao;
    logic [12*NZ-1:0]  radiacao;
    logic              reconhecer = 1'b0;
    logic [3:0]        reconhecer_zona = 4'd0;
    logic [NZ-1:0]     alarme_zona;
    logic              alarmeSonoro;
    logic              scram;
    logic [3:0]        zona_atual;
    logic              varredura_fim;

    escalonador_alarmes #(.NZ(NZ), .PERSIST(3), .ACK_TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .temp            (temp),
        .pressao         (pressao),
        .radiacao        (radiacao),
        .reconhecer      (reconhecer),
        .reconhecer_zona (reconhecer_zona),
        .alarme_zona     (alarme_zona),
        .alarmeSonoro    (alarmeSonoro),
        .scram           (scram),
        .zona_atual      (zona_atual),
        .varredura_fim   (varredura_fim)
    );

    always #5 clk = ~clk;

    // kind: 0 alarme_zona, 1 alarmeSonoro, 2 scram, 3 zona_atual, 4 varredura_fim
    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    function automatic void esperar(int c, int k, logic [3:0] v, string n);
        exp_t x;
        x.cyc = c; x.kind = k; x.val = v; x.name = n;
        sb.push_back(x);
    endfunction

    function automatic logic [3:0] obs(int k);
        case (k)
            0:       return alarme_zona;
            1:       return {3'b000, alarmeSonoro};
            2:       return {3'b000, scram};
            3:       return zona_atual;
            default: return {3'b000, varredura_fim};
        endcase
    endfunction

    task automatic set_zone(int z, logic [7:0] t, logic [3:0] p, logic [11:0] r);
        temp[8*z +: 8]      = t;
        pressao[4*z +: 4]   = p;
        radiacao[12*z +: 12] = r;
    endtask

    task automatic all_clean();
        for (int z = 0; z < NZ; z++) set_zone(z, 8'd20, 4'd2, 12'd100);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        reconhecer = 1'b0;
        cyc        = 0;
    endtask

    task automatic ack(logic [3:0] z);
        reconhecer      = 1'b1;
        reconhecer_zona = z;
    endtask

    task automatic test_reset();
        all_clean();
        apply_reset(2);
        esperar(0, 0, 4'h0, "rst_alarme");  esperar(0, 1, 4'h0, "rst_sonoro");
        esperar(0, 2, 4'h0, "rst_scram");   esperar(0, 3, 4'h0, "rst_zona");
        esperar(0, 4, 4'h0, "rst_fim");     esperar(1, 3, 4'h0, "zona_c1");
        esperar(2, 3, 4'h1, "zona_c2");     esperar(5, 3, 4'h2, "zona_c5");
        esperar(6, 3, 4'h3, "zona_c6");     esperar(6, 4, 4'h0, "fim_c6");
        esperar(7, 3, 4'h3, "zona_c7");     esperar(7, 4, 4'h1, "fim_c7");
        esperar(8, 3, 4'h0, "zona_c8");     esperar(8, 4, 4'h0, "fim_c8");
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_latch_scram();
        all_clean();
        apply_reset(2);
        set_zone(2, 8'd40, 4'd2, 12'd100);
        esperar(21, 0, 4'h0, "latch_alarme_c21"); esperar(21, 1, 4'h0, "latch_sonoro_c21");
        esperar(22, 0, 4'h4, "latch_alarme_c22"); esperar(22, 1, 4'h1, "latch_sonoro_c22");
        esperar(37, 2, 4'h0, "latch_scram_c37");  esperar(38, 2, 4'h1, "latch_scram_c38");
        for (int c = 0; c <= 38; c++) begin
            if (c > 0) tick();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_transient();
        for (int k = 0; k < 3; k++) begin
            all_clean();
            apply_reset(2);
            esperar(20, 0, 4'h0, "trans_alarme_c20"); esperar(28, 0, 4'h0, "trans_alarme_c28");
            esperar(36, 0, 4'h0, "trans_alarme_c36"); esperar(36, 1, 4'h0, "trans_sonoro_c36");
            esperar(44, 0, 4'h0, "trans_alarme_c44");
            for (int c = 0; c <= 44; c++) begin
                if (c > 0) tick();
                if (c == 0 || c == 24) begin
                    case (k)
                        0:       set_zone(1, 8'd20, 4'd2, 12'd1000);
                        1:       set_zone(1, 8'd20, 4'd7, 12'd100);
                        default: set_zone(1, 8'd40, 4'd2, 12'd100);
                    endcase
                end
                if (c == 16 || c == 40) begin
                    case (k)
                        0:       set_zone(1, 8'd20, 4'd2, 12'd999);
                        1:       set_zone(1, 8'd20, 4'd6, 12'd100);
                        default: set_zone(1, 8'd39, 4'd2, 12'd100);
                    endcase
                end
                while (sb.size() != 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    n_vec++;
                    if (obs(e.kind) !== e.val) begin
                        n_err++;
                        $display("FAIL %s k=%0d cyc=%0d got=%0h expected=%0h", e.name, k, cyc, obs(e.kind), e.val);
                    end
                end
            end
        end
    endtask

    task automatic test_ack_clear();
        all_clean();
        apply_reset(2);
        esperar(17, 0, 4'h0, "ack_alarme_c17");
        esperar(18, 0, 4'h1, "ack_alarme_c18"); esperar(18, 1, 4'h1, "ack_sonoro_c18");
        esperar(20, 1, 4'h1, "ack_sonoro_c20");
        esperar(21, 1, 4'h0, "ack_sonoro_c21"); esperar(21, 0, 4'h1, "ack_alarme_c21");
        esperar(30, 0, 4'h1, "ack_alarme_c30"); esperar(33, 0, 4'h1, "ack_alarme_c33");
        esperar(34, 0, 4'h0, "ack_alarme_c34"); esperar(57, 1, 4'h0, "ack_sonoro_c57");
        esperar(58, 0, 4'h1, "ack_alarme_c58"); esperar(58, 1, 4'h1, "ack_sonoro_c58");
        esperar(73, 2, 4'h0, "ack_scram_c73");  esperar(74, 2, 4'h1, "ack_scram_c74");
        for (int c = 0; c <= 74; c++) begin
            if (c > 0) tick();
            if (c == 0 || c == 36) set_zone(0, 8'd40, 4'd2, 12'd100);
            if (c == 20) ack(4'd0);
            if (c == 21) reconhecer = 1'b0;
            if (c == 30) set_zone(0, 8'd39, 4'd2, 12'd100);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_scram_sticky();
        all_clean();
        apply_reset(2);
        esperar(23, 0, 4'h0, "stk_alarme_c23");
        esperar(24, 0, 4'h8, "stk_alarme_c24"); esperar(24, 1, 4'h1, "stk_sonoro_c24");
        esperar(27, 1, 4'h1, "stk_ack9_c27");   esperar(29, 1, 4'h1, "stk_ack11_c29");
        esperar(39, 2, 4'h0, "stk_scram_c39");  esperar(40, 2, 4'h1, "stk_scram_c40");
        esperar(43, 1, 4'h0, "stk_sonoro_c43"); esperar(43, 2, 4'h1, "stk_scram_c43");
        esperar(47, 0, 4'h8, "stk_alarme_c47"); esperar(48, 0, 4'h0, "stk_alarme_c48");
        esperar(60, 2, 4'h1, "stk_scram_c60");
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) tick();
            if (c == 0)  set_zone(3, 8'd20, 4'd7, 12'd100);
            if (c == 26) ack(4'd9);
            if (c == 28) ack(4'd11);
            if (c == 27 || c == 29 || c == 43) reconhecer = 1'b0;
            if (c == 42) begin
                ack(4'd3);
                set_zone(3, 8'd20, 4'd6, 12'd100);
            end
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
        apply_reset(1);
        esperar(0, 2, 4'h0, "stk_scram_rst"); esperar(0, 1, 4'h0, "stk_sonoro_rst");
        while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (obs(e.kind) !== e.val) begin
                n_err++;
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        all_clean();
        apply_reset(2);
        esperar(22, 1, 4'h0, "same_sonoro_c22");
        esperar(24, 0, 4'h8, "same_alarme_c24"); esperar(24, 1, 4'h1, "same_sonoro_c24");
        esperar(30, 1, 4'h1, "same_sonoro_c30");
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) tick();
            if (c == 0)  set_zone(3, 8'd20, 4'd2, 12'd1000);
            if (c == 5 || c == 23) ack(4'd3);
            if (c == 6 || c == 24) reconhecer = 1'b0;
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        all_clean();
        apply_reset(2);
        esperar(14, 0, 4'h0, "mid_alarme_pre");
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) tick();
            if (c == 0) set_zone(2, 8'd40, 4'd2, 12'd100);
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
        apply_reset(1);
        esperar(0, 0, 4'h0, "mid_alarme_c0"); esperar(0, 1, 4'h0, "mid_sonoro_c0");
        esperar(0, 2, 4'h0, "mid_scram_c0");  esperar(0, 3, 4'h0, "mid_zona_c0");
        esperar(0, 4, 4'h0, "mid_fim_c0");    esperar(6, 0, 4'h0, "mid_alarme_c6");
        esperar(14, 0, 4'h0, "mid_alarme_c14"); esperar(21, 0, 4'h0, "mid_alarme_c21");
        esperar(22, 0, 4'h4, "mid_alarme_c22");
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) tick();
            while (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (obs(e.kind) !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h expected=%0h", e.name, cyc, obs(e.kind), e.val);
                end
            end
        end
    endtask

    initial begin
        all_clean();
        test_reset();
        test_latch_scram();
        test_transient();
        test_ack_clear();
        test_scram_sticky();
        test_back_to_back();
        test_reset_midscan();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/escalonador_alarmes.md
# escalonador_alarmes

Round-robin alarm sequencer for the plant's monitored zones (control room, reactor hall, turbine hall, etc.). It scans each zone's temperature, pressure and radiation buses through one shared threshold check, and filters transients with a per-zone persistence count. It latches zone alarms, drives the plant sounder until each pending alarm is acknowledged, and raises a sticky SCRAM request if any alarm stays unacknowledged too long. It sits between the per-zone sensor buses and the central alarm panel / reactor protection logic.

## Interface
Parameters:
- NZ, 4: number of zones scanned (2..16).
- PERSIST, 3: consecutive violating evaluations needed to latch a zone alarm (1..7).
- ACK_TIMEOUT, 16: consecutive cycles with any pending alarm before SCRAM (2..255).

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- temp  in  8*NZ  zone z occupies bits [8z+7:8z], unsigned °C.
- pressao  in  4*NZ  zone z occupies bits [4z+3:4z].
- radiacao  in  12*NZ  zone z occupies bits [12z+11:12z], unsigned mSv.
- reconhecer  in  1  acknowledge strobe, one cycle.
- reconhecer_zona  in  4  zone being acknowledged.
- alarme_zona  out  NZ  latched per-zone alarm.
- alarmeSonoro  out  1  OR of pending (unacknowledged) alarms.
- scram  out  1  sticky SCRAM request.
- zona_atual  out  4  zone currently being scanned.
- varredura_fim  out  1  one-cycle pulse on the evaluation of zone NZ-1.

## Operation
- Two-state FSM per zone:
  - CAPTURA: register the temp/pressao/radiacao slices of zone zona_atual; go to AVALIA.
  - AVALIA: compare the registered sample, update that zone; zona_atual wraps NZ-1 → 0; go to CAPTURA.
- Violation (unsigned compares): temp >= 40, or pressao >= 7, or radiacao >= 1000. Values 39, 6 and 999 are not violations.
- Sensor inputs are sampled only in CAPTURA; changes in other cycles are invisible.
- Per-zone persistence counter cnt[z], width clog2(PERSIST+1):
  - AVALIA with violation: cnt saturating +1. On reaching PERSIST, set alarme_zona[z]=1 and pendente[z]=1.
  - AVALIA without violation: cnt=0.
  - While the violation persists after latching, cnt stays at PERSIST and pendente is not re-set.
- alarme_zona[z] clears only in an AVALIA of zone z with no violation and pendente[z]=0.
- Acknowledge:
  - reconhecer=1 with reconhecer_zona<NZ clears pendente[z].
  - Zone index >= NZ is ignored, as is an ack of a non-pending zone.
  - If an ack and a latch hit the same zone in the same cycle, the latch wins and pendente stays 1.
- alarmeSonoro = |pendente (combinational from registers).
- Timeout counter:
  - Increments each cycle with |pendente=1; cleared to 0 in any cycle with |pendente=0.
  - Saturates at ACK_TIMEOUT, at which point scram is set.
  - scram stays 1 until rst; ack does not clear it.
- Reset values: state=CAPTURA, zona_atual=0, all cnt/pendente/alarme_zona=0, timeout=0, scram=0, varredura_fim=0, alarmeSonoro=0.

## Timing
- Cycle 0 is the first cycle with rst=0. Zone z is in CAPTURA at cycle 2z+8k and in AVALIA at cycle 2z+1+8k (NZ=4); one full scan is 2*NZ cycles.
- Results of an AVALIA at cycle n are visible from cycle n+1.
- Steady violation latency from cycle 0 for zone z: alarme_zona visible at 2z+2+2*NZ*(PERSIST-1).
- scram rises one cycle after ACK_TIMEOUT consecutive cycles with |pendente=1.
- rst asserted mid-scan forces the reset values at the next edge; any partial persistence count is discarded.
- varredura_fim is high during the AVALIA cycle of zone NZ-1 (registered decode).

## Test plan
- Zone 2 temp=40 steady from cycle 0, others clean → evaluations at cycles 5, 13, 21; alarme_zona=4'b0100 and alarmeSonoro=1 from cycle 22; timeout reaches 16, scram=1 from cycle 38.
- Zone 1 radiacao=1000 for two scans then 999 → cnt returns to 0, alarme_zona stays 0; repeat with pressao=7 vs 6 and temp 40 vs 39.
- Latch zone 0, ack zone 0 before timeout → alarmeSonoro=0 next cycle, timeout=0, alarme_zona[0] stays 1 while violating; clear input → alarme_zona[0]=0 after zone 0's next AVALIA.
- Latched alarm never acked → scram=1; then ack and clear inputs → scram stays 1 until rst pulse; reconhecer_zona=9 has no effect.
- Ack zone 3 in the same cycle zone 3 latches → pendente[3] stays 1, alarmeSonoro=1.
- rst in zone 2's CAPTURA with cnt[2]=2 → all outputs at reset values next cycle, zona_atual=0, and the alarm needs three fresh evaluations to latch.
